// File: rtl/mem_fill_engine.sv
// mem_fill_engine: fills DEPTH words of a single-port RAM from address 0
// with one of four patterns, one word per clock, after an en/rdy start.
// Optional read-back verify pass: define MEM_FILL_VERIFY_EN.
//
// state  | meaning
// IDLE   | rdy=1, waiting for en
// WRITE  | driving wren=1, addr=k, wrdata=f(k) for k=0..DEPTH-1
// VERIFY | driving addr=k with wren=0 so the RAM returns word k next cycle
// VCMP   | last read-back compare, then done
module mem_fill_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [DATA_W-1:0] step,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wrdata,
    output logic              wren,
    output logic              done
`ifdef MEM_FILL_VERIFY_EN
    ,
    input  logic [DATA_W-1:0] rddata,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
`endif
);

    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_depth_chk
        $error("mem_fill_engine: DEPTH must be in 1..2**ADDR_W");
    end

    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] DESC0 = DATA_W'(DEPTH - 1);

`ifdef MEM_FILL_VERIFY_EN
    typedef enum logic [1:0] {IDLE, WRITE, VERIFY, VCMP} state_t;
`else
    typedef enum logic [1:0] {IDLE, WRITE} state_t;
`endif

    state_t            state;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] seed_q;
    logic [DATA_W-1:0] step_q;

`ifdef MEM_FILL_VERIFY_EN
    logic [DATA_W-1:0] exp_data;
    logic              cmp_valid;
    logic [ADDR_W-1:0] cmp_addr;
    logic [DATA_W-1:0] cmp_exp;
`endif

    // Pattern value for k=0.
    function automatic logic [DATA_W-1:0] first_val(input logic [1:0] m,
                                                    input logic [DATA_W-1:0] s);
        case (m)
            2'd0:    first_val = '0;
            2'd1:    first_val = s;
            2'd2:    first_val = s;
            default: first_val = DESC0;
        endcase
    endfunction

    // f(k+1) from f(k); the running value doubles as the mode-2 accumulator.
    function automatic logic [DATA_W-1:0] next_val(input logic [1:0] m,
                                                   input logic [DATA_W-1:0] cur,
                                                   input logic [DATA_W-1:0] s,
                                                   input logic [DATA_W-1:0] st);
        case (m)
            2'd0:    next_val = cur + DATA_W'(1);
            2'd1:    next_val = s;
            2'd2:    next_val = cur + st;
            default: next_val = cur - DATA_W'(1);
        endcase
    endfunction

    // Sequencer: handshake, write walk, optional verify walk, registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rdy    <= 1'b1;
            wren   <= 1'b0;
            addr   <= '0;
            wrdata <= '0;
            done   <= 1'b0;
            mode_q <= 2'd0;
            seed_q <= '0;
            step_q <= '0;
`ifdef MEM_FILL_VERIFY_EN
            exp_data  <= '0;
            cmp_valid <= 1'b0;
            cmp_addr  <= '0;
            cmp_exp   <= '0;
            err       <= 1'b0;
            err_addr  <= '0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MEM_FILL_VERIFY_EN
            // rddata belongs to the address presented one cycle earlier
            if (cmp_valid && (rddata != cmp_exp) && !err) begin
                err      <= 1'b1;
                err_addr <= cmp_addr;
            end
`endif
            case (state)
                IDLE: begin
                    if (en) begin
                        state  <= WRITE;
                        rdy    <= 1'b0;
                        wren   <= 1'b1;
                        addr   <= '0;
                        wrdata <= first_val(mode, seed);
                        mode_q <= mode;
                        seed_q <= seed;
                        step_q <= step;
`ifdef MEM_FILL_VERIFY_EN
                        err      <= 1'b0;
                        err_addr <= '0;
`endif
                    end
                end
                WRITE: begin
                    // compare against LAST so a full 2**ADDR_W fill never wraps
                    if (addr == LAST) begin
                        wren <= 1'b0;
`ifdef MEM_FILL_VERIFY_EN
                        state    <= VERIFY;
                        addr     <= '0;
                        exp_data <= first_val(mode_q, seed_q);
`else
                        state <= IDLE;
                        done  <= 1'b1;
                        rdy   <= 1'b1;
`endif
                    end else begin
                        addr   <= addr + ADDR_W'(1);
                        wrdata <= next_val(mode_q, wrdata, seed_q, step_q);
                    end
                end
`ifdef MEM_FILL_VERIFY_EN
                VERIFY: begin
                    cmp_valid <= 1'b1;
                    cmp_addr  <= addr;
                    cmp_exp   <= exp_data;
                    if (addr == LAST) begin
                        state <= VCMP;
                    end else begin
                        addr     <= addr + ADDR_W'(1);
                        exp_data <= next_val(mode_q, exp_data, seed_q, step_q);
                    end
                end
                VCMP: begin
                    cmp_valid <= 1'b0;
                    state     <= IDLE;
                    done      <= 1'b1;
                    rdy       <= 1'b1;
                end
`endif
                default: begin
                    state <= IDLE;
                    rdy   <= 1'b1;
                    wren  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_fill_engine.sv
// Directed bench for mem_fill_engine: a 256x8 instance and a 16x4 full-depth instance.
module tb_mem_fill_engine;

`ifdef MEM_FILL_VERIFY_EN
    localparam int FILL_CYC   = 2 * 256 + 2;
    localparam int FILL_CYC_S = 2 * 16 + 2;
`else
    localparam int FILL_CYC   = 256 + 1;
    localparam int FILL_CYC_S = 16 + 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rdy;
    logic [1:0] mode;
    logic [7:0] seed;
    logic [7:0] step;
    logic [7:0] addr;
    logic [7:0] wrdata;
    logic       wren;
    logic       done;

    logic       en_s;
    logic       rdy_s;
    logic [1:0] mode_s;
    logic [3:0] seed_s;
    logic [3:0] step_s;
    logic [3:0] addr_s;
    logic [3:0] wrdata_s;
    logic       wren_s;
    logic       done_s;

`ifdef MEM_FILL_VERIFY_EN
    logic [7:0] rddata;
    logic       err;
    logic [7:0] err_addr;
    logic       err_s;
    logic [3:0] err_addr_s;
    logic       corrupt = 1'b0;
    logic [7:0] ram [256];

    always @(posedge clk) begin
        if (wren) ram[addr] <= (corrupt && addr == 8'd7) ? (wrdata ^ 8'h01) : wrdata;
        rddata <= ram[addr];
    end
`endif

    always #5 clk = ~clk;

    mem_fill_engine #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy), .mode(mode), .seed(seed),
        .step(step), .addr(addr), .wrdata(wrdata), .wren(wren), .done(done)
`ifdef MEM_FILL_VERIFY_EN
        , .rddata(rddata), .err(err), .err_addr(err_addr)
`endif
    );

    mem_fill_engine #(.ADDR_W(4), .DATA_W(4), .DEPTH(16)) dut_s (
        .clk(clk), .rst(rst), .en(en_s), .rdy(rdy_s), .mode(mode_s), .seed(seed_s),
        .step(step_s), .addr(addr_s), .wrdata(wrdata_s), .wren(wren_s), .done(done_s)
`ifdef MEM_FILL_VERIFY_EN
        , .rddata(4'h0), .err(err_s), .err_addr(err_addr_s)
`endif
    );

    int vec_cnt  = 0;
    int miscomp  = 0;

    typedef struct {
        logic [1:0] m;
        logic [7:0] s;
        logic [7:0] st;
        int         k;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscomp++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [1:0] m, input logic [7:0] s, input logic [7:0] st);
        en   = 1'b1;
        mode = m;
        seed = s;
        step = st;
        tick();
        en = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!rdy && n < 3000) begin
            tick();
            n++;
        end
        chk(name, rdy, 1);
    endtask

    initial begin
        int bad;
        int dones;
        int wrens;

        vecs[0]  = '{2'd0, 8'h00, 8'h00, 0,   8'h00};
        vecs[1]  = '{2'd0, 8'h00, 8'h00, 77,  8'h4D};
        vecs[2]  = '{2'd0, 8'h00, 8'h00, 255, 8'hFF};
        vecs[3]  = '{2'd1, 8'hA5, 8'h00, 0,   8'hA5};
        vecs[4]  = '{2'd1, 8'hA5, 8'h00, 200, 8'hA5};
        vecs[5]  = '{2'd2, 8'h10, 8'h03, 0,   8'h10};
        vecs[6]  = '{2'd2, 8'h10, 8'h03, 1,   8'h13};
        vecs[7]  = '{2'd2, 8'h10, 8'h03, 85,  8'h0F};
        vecs[8]  = '{2'd2, 8'h10, 8'h03, 255, 8'h0D};
        vecs[9]  = '{2'd3, 8'h00, 8'h00, 0,   8'hFF};
        vecs[10] = '{2'd3, 8'h00, 8'h00, 100, 8'h9B};
        vecs[11] = '{2'd3, 8'h00, 8'h00, 255, 8'h00};
        vecs[12] = '{2'd2, 8'hFF, 8'h80, 3,   8'h7F};

        rst = 1'b1; en = 1'b0; mode = 2'd0; seed = 8'h00; step = 8'h00;
        en_s = 1'b0; mode_s = 2'd0; seed_s = 4'h0; step_s = 4'h0;
        repeat (2) tick();
        chk("rst_rdy", rdy, 1);
        chk("rst_wren", wren, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wrdata", wrdata, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        tick();

        // full identity fill with exact timing
        start(2'd0, 8'h00, 8'h00);
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            if (!(wren && !rdy && !done && addr == 8'(k) && wrdata == 8'(k))) bad++;
            tick();
        end
        chk("id_write_cycles", bad, 0);
        repeat (FILL_CYC - 257) tick();
        chk("id_done", done, 1);
        chk("id_rdy", rdy, 1);
        chk("id_wren_off", wren, 0);
        tick();
        chk("id_done_pulse", done, 0);

        // pattern vectors
        for (int i = 0; i < 13; i++) begin
            wait_idle($sformatf("vec%0d_idle", i));
            start(vecs[i].m, vecs[i].s, vecs[i].st);
            repeat (vecs[i].k) tick();
            chk($sformatf("vec%0d_addr", i), addr, vecs[i].k);
            chk($sformatf("vec%0d_wrdata", i), wrdata, vecs[i].exp);
            chk($sformatf("vec%0d_wren", i), wren, 1);
        end
        wait_idle("vec_end_idle");

        // 16x4 full-depth descending fill, no wrap back into WRITE
        en_s = 1'b1; mode_s = 2'd3;
        tick();
        en_s = 1'b0;
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (!(wren_s && addr_s == 4'(k) && wrdata_s == 4'(15 - k))) bad++;
            tick();
        end
        chk("small_write_cycles", bad, 0);
        repeat (FILL_CYC_S - 17) tick();
        chk("small_done", done_s, 1);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (wren_s || done_s || !rdy_s) bad++;
        end
        chk("small_no_rewrite", bad, 0);

        // reset in the middle of a fill
        start(2'd2, 8'h10, 8'h03);
        repeat (100) tick();
        chk("mid_addr", addr, 100);
        chk("mid_wrdata", wrdata, 8'h3C);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_wren", wren, 0);
        chk("mid_rst_rdy", rdy, 1);
        chk("mid_rst_done", done, 0);
        dones = 0; wrens = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (done) dones++;
            if (wren) wrens++;
        end
        chk("mid_no_done", dones, 0);
        chk("mid_no_wren", wrens, 0);
        start(2'd0, 8'h00, 8'h00);
        chk("restart_addr0", addr, 0);
        chk("restart_wren", wren, 1);
        tick();
        chk("restart_addr1", addr, 1);
        wait_idle("restart_idle");

        // en held high: back-to-back fills, seed change while busy
        en = 1'b1; mode = 2'd1; seed = 8'h3C;
        tick();
        bad = 0; dones = 0; wrens = 0;
        for (int c = 1; c <= 2 * FILL_CYC + 10; c++) begin
            if (c == 10) seed = 8'hC3;
            if (done) dones++;
            if (wren) begin
                wrens++;
                if (wrdata != ((c <= 256) ? 8'h3C : 8'hC3)) bad++;
            end
            if (done && c != FILL_CYC && c != 2 * FILL_CYC) bad++;
            tick();
        end
        en = 1'b0;
        chk("b2b_dones", dones, 2);
        chk("b2b_wrens", wrens, 522);
        chk("b2b_data_timing", bad, 0);
        wait_idle("b2b_idle");

`ifdef MEM_FILL_VERIFY_EN
        corrupt = 1'b1;
        start(2'd0, 8'h00, 8'h00);
        repeat (512) tick();
        chk("ver_done_early", done, 0);
        tick();
        chk("ver_done", done, 1);
        chk("ver_err", err, 1);
        chk("ver_err_addr", err_addr, 7);
        corrupt = 1'b0;
        tick();
        chk("ver_err_sticky", err, 1);
        start(2'd0, 8'h00, 8'h00);
        chk("ver_err_clr", err, 0);
        wait_idle("ver_idle");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscomp);
        $finish;
    end

endmodule
